// File: rtl/irrigation_seq_ctrl_if.sv
// Sensor inputs and valve/indicator outputs of the irrigation sequencer.
// The master side drives the sensors; the slave side is the controller.
interface irrigation_seq_ctrl_if;
  logic       soil_dry;
  logic       tank_low;
  logic       man_req;
  logic       alarm_clr;
  logic       valve_on;
  logic       alarm;
  logic       busy;
  logic       done;
  logic [2:0] state;
  logic [3:0] cycle_cnt;

  modport master (
    output soil_dry, tank_low, man_req, alarm_clr,
    input  valve_on, alarm, busy, done, state, cycle_cnt
  );

  modport slave (
    input  soil_dry, tank_low, man_req, alarm_clr,
    output valve_on, alarm, busy, done, state, cycle_cnt
  );
endinterface

// File: rtl/irrigation_seq_ctrl.sv
// Irrigation valve sequencer: bounded WATER/SOAK cycles timed by a synchronous
// prescaler tick, with tank-low abort and a latched dry-soil/low-tank alarm.
module irrigation_seq_ctrl #(
  parameter int PRESC_W     = 10,
  parameter int WATER_TICKS = 8,
  parameter int SOAK_TICKS  = 4,
  parameter int MAX_CYCLES  = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  irrigation_seq_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WATER = 3'd1,
    S_SOAK  = 3'd2,
    S_CHECK = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  // Bit order {alarm_clr, man_req, tank_low, soil_dry}
  logic [3:0] w_async;
  logic [3:0] r_meta;
  logic [3:0] r_sync_s;
  logic       w_soil_dry_s;
  logic       w_tank_low_s;
  logic       w_man_req_s;
  logic       w_alarm_clr_s;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cycle_cnt;
  logic [3:0]         w_cycle_nxt;
  logic               w_done_nxt;
  logic [PRESC_W-1:0] r_presc;
  logic [7:0]         r_tick_cnt;
  logic               w_tick;
  logic               w_phase_entry;
  logic               r_valve_on;
  logic               r_alarm;
  logic               r_busy;
  logic               r_done;

  assign w_async = {io.alarm_clr, io.man_req, io.tank_low, io.soil_dry};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta   <= '0;
      r_sync_s <= '0;
    end else begin
      r_meta   <= w_async;
      r_sync_s <= r_meta;
    end
  end

  assign w_soil_dry_s  = r_sync_s[0];
  assign w_tank_low_s  = r_sync_s[1];
  assign w_man_req_s   = r_sync_s[2];
  assign w_alarm_clr_s = r_sync_s[3];

  assign w_tick = &r_presc;

  always_comb begin
    w_state_nxt = r_state;
    w_cycle_nxt = r_cycle_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_soil_dry_s || w_man_req_s) begin
          if (w_tank_low_s) begin
            w_state_nxt = S_ALARM;
          end else begin
            w_state_nxt = S_WATER;
            w_cycle_nxt = 4'd0;
          end
        end
      end
      S_WATER: begin
        // Tank-low wins over a phase expiry landing in the same cycle
        if (w_tank_low_s)
          w_state_nxt = S_ALARM;
        else if (w_tick && r_tick_cnt == 8'(WATER_TICKS - 1))
          w_state_nxt = S_SOAK;
      end
      S_SOAK: begin
        if (w_tank_low_s)
          w_state_nxt = S_ALARM;
        else if (w_tick && r_tick_cnt == 8'(SOAK_TICKS - 1))
          w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!w_soil_dry_s) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_cycle_cnt == 4'(MAX_CYCLES - 1)) begin
          w_state_nxt = S_ALARM;
        end else begin
          w_state_nxt = S_WATER;
          w_cycle_nxt = r_cycle_cnt + 4'd1;
        end
      end
      S_ALARM: begin
        if (w_alarm_clr_s && !w_tank_low_s)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Phase timing restarts from zero on every entry so each phase is exact
  assign w_phase_entry = ((w_state_nxt == S_WATER) && (r_state != S_WATER)) ||
                         ((w_state_nxt == S_SOAK)  && (r_state != S_SOAK));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end else if (w_phase_entry) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_tick && r_tick_cnt != 8'hFF)
        r_tick_cnt <= r_tick_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cycle_cnt <= '0;
      r_valve_on  <= 1'b0;
      r_alarm     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cycle_cnt <= w_cycle_nxt;
      r_valve_on  <= (w_state_nxt == S_WATER);
      r_alarm     <= (w_state_nxt == S_ALARM);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
    end
  end

  assign io.valve_on  = r_valve_on;
  assign io.alarm     = r_alarm;
  assign io.busy      = r_busy;
  assign io.done      = r_done;
  assign io.state     = r_state;
  assign io.cycle_cnt = r_cycle_cnt;

endmodule

// File: doc/irrigation_seq_ctrl.md
Name: irrigation_seq_ctrl

Overview:
- Sequences the irrigation valve using a tick generated by an internal prescaler, a synchronous replacement for the ripple divider chain.
- Runs bounded water/soak cycles while the soil sensor reports dry, and stops on low tank.
- Raises a latched alarm when the soil stays dry after the maximum number of cycles.
- Sits between the sensor inputs (soil, tank, manual button) and the valve driver/indicator LEDs.

Parameters:
- PRESC_W, 10, prescaler width; one tick every 2^PRESC_W clk cycles (1024 by default).
- WATER_TICKS, 8, ticks per WATER phase (range 1..255).
- SOAK_TICKS, 4, ticks per SOAK phase (range 1..255).
- MAX_CYCLES, 3, water+soak cycles before a dry-soil fault (range 1..15).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- soil_dry  in  1  async soil sensor; 1 = dry
- tank_low  in  1  async reservoir sensor; 1 = low
- man_req  in  1  manual water request, level, async
- alarm_clr  in  1  alarm acknowledge, level, async
- valve_on  out  1  valve drive
- alarm  out  1  latched fault indicator
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on successful completion
- state  out  3  IDLE=0, WATER=1, SOAK=2, CHECK=3, ALARM=4
- cycle_cnt  out  4  index of the current cycle, 0-based

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE, valve_on=0, alarm=0, done=0, cycle_cnt=0.
  - Prescaler, tick counter and all synchronizer flops = 0.
  - Reset mid-WATER closes the valve immediately; no state survives reset.
- Synchronization:
  - All four async inputs pass through 2-flop synchronizers (suffix _s).
  - Decisions use only the _s values, so input-to-decision latency is 2 clk.
- Prescaler:
  - Free-running PRESC_W-bit up-counter.
  - tick=1 in the cycle the count equals all-ones; wraps to 0.
  - Prescaler and tick counter clear to 0 on every entry into WATER or SOAK.
  - WATER therefore lasts exactly WATER_TICKS*2^PRESC_W cycles; SOAK lasts SOAK_TICKS*2^PRESC_W cycles.
- IDLE:
  - If tank_low_s and (soil_dry_s or man_req_s), go to ALARM.
  - Else if soil_dry_s or man_req_s, go to WATER with cycle_cnt=0.
- WATER:
  - valve_on=1, registered; it rises the cycle state becomes WATER.
  - If tank_low_s, go to ALARM next cycle; this has priority over tick expiry in the same cycle.
  - Else on tick with tick_cnt==WATER_TICKS-1, go to SOAK.
- SOAK:
  - valve_on=0.
  - If tank_low_s, go to ALARM.
  - Else on tick with tick_cnt==SOAK_TICKS-1, go to CHECK.
- CHECK (exactly 1 cycle):
  - If !soil_dry_s, go to IDLE and pulse done=1 for 1 cycle.
  - Else if cycle_cnt==MAX_CYCLES-1, go to ALARM.
  - Else increment cycle_cnt and go to WATER.
  - man_req_s is ignored here; a manual cycle ends when the soil reads wet or the cycle limit is reached.
- ALARM:
  - alarm=1 and valve_on=0.
  - Exit to IDLE only when alarm_clr_s=1 and tank_low_s=0.
  - Holding alarm_clr while the tank is low keeps the block in ALARM.
  - alarm clears the cycle the state leaves ALARM.
- Counters:
  - tick_cnt is 8 bits and never wraps within a phase.
  - cycle_cnt holds its value in IDLE until the next start, which reloads it to 0.
- Outputs: all registered, none combinational from the inputs.

Test Plan (PRESC_W=2, WATER_TICKS=3, SOAK_TICKS=2, MAX_CYCLES=2):
1. Reset then soil_dry=1 → WATER 3 clk after the input edge. valve_on high for exactly 12 clk, then SOAK for 8 clk, then CHECK. Drop soil_dry during SOAK → IDLE, done pulses 1 clk, cycle_cnt=0.
2. soil_dry held at 1 → two full cycles with cycle_cnt 0 then 1. The second CHECK goes to ALARM; alarm=1, valve_on=0. Pulse alarm_clr → IDLE.
3. tank_low asserted mid-WATER (cycle 5 of 12) → valve_on falls 3 clk later and state=ALARM. alarm_clr with tank_low=1 → remains in ALARM. Release tank_low → IDLE.
4. soil_dry=0, man_req=1 for 1 clk while tank OK → one WATER/SOAK/CHECK sequence, then IDLE with done=1.
5. Assert rstn=0 mid-SOAK on cycle 1 → all outputs 0 and state=IDLE asynchronously, before the next clk edge. After release, behaviour matches scenario 1 from fresh.
6. tank_low and tick expiry land in the same WATER cycle → next state is ALARM, not SOAK.
